// File: rtl/uart_pwm_frame_ctrl.sv
// rtl/uart_pwm_frame_ctrl.sv - UART byte-stream frame parser driving double-buffered PWM outputs
//
// Parses frames of the form SYNC_BYTE, 2*NUM_CH payload bytes (one 16-bit
// word per channel, channel 0 first, high byte first), then an XOR checksum.
// Good frames load a shadow duty set; the shadow is copied to the active set
// only at the last count of a PWM period, so every channel changes together.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   rx_data    in   [7:0] received byte
//   rx_valid   in   one-cycle strobe qualifying rx_data
//   pwm_out    out  [NUM_CH-1:0] registered PWM outputs
//   frame_ok   out  pulse: frame checksum matched
//   frame_err  out  pulse: checksum mismatch or inter-byte timeout
//   commit     out  pulse: shadow duties loaded into active set
//   busy       out  high while a frame is being received (PAYLOAD/CHECK)
//   pkt_count  out  [3:0] good-frame counter, wraps
module uart_pwm_frame_ctrl #(
  parameter int unsigned NUM_CH       = 9,
  parameter int unsigned PWM_W        = 16,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS = 8680
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              frame_ok,
  output logic              frame_err,
  output logic              commit,
  output logic              busy,
  output logic [3:0]        pkt_count
);

  localparam int unsigned NBYTES = 2 * NUM_CH;
  localparam int unsigned IDX_W  = $clog2(NBYTES);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CLKS + 1);

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CHECK} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         xor_q, xor_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [7:0]         rx_buf_q [NBYTES];
  logic [7:0]         rx_buf_d [NBYTES];
  logic [PWM_W-1:0]   shadow_q [NUM_CH];
  logic [PWM_W-1:0]   shadow_d [NUM_CH];
  logic [PWM_W-1:0]   active_q [NUM_CH];
  logic [PWM_W-1:0]   active_d [NUM_CH];
  logic               pending_q, pending_d;
  logic [PWM_W-1:0]   cnt_q, cnt_d;
  logic [NUM_CH-1:0]  pwm_q, pwm_d;
  logic               frame_ok_q, frame_ok_d;
  logic               frame_err_q, frame_err_d;
  logic               commit_q, commit_d;
  logic               busy_q, busy_d;
  logic [3:0]         pkt_q, pkt_d;

  logic               in_frame;
  logic               timeout;
  logic               good;
  logic [15:0]        word;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    xor_d       = xor_q;
    rx_buf_d    = rx_buf_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    pending_d   = pending_q;
    pkt_d       = pkt_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    commit_d    = 1'b0;
    good        = 1'b0;
    word        = '0;
    cnt_d       = cnt_q + 1'b1;

    // A byte arriving in the same cycle the idle count expires wins: the
    // counter is only considered expired when no byte is present.
    in_frame = (state_q != S_IDLE);
    tmo_d    = (in_frame && !rx_valid) ? tmo_q + 1'b1 : '0;
    timeout  = in_frame && !rx_valid && (tmo_q == TMO_W'(TIMEOUT_CLKS - 1));

    case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d = S_PAYLOAD;
          idx_d   = '0;
          xor_d   = '0;
        end
      end
      S_PAYLOAD: begin
        // SYNC_BYTE values here are ordinary payload, never a resync.
        if (rx_valid) begin
          rx_buf_d[idx_q] = rx_data;
          xor_d           = xor_q ^ rx_data;
          idx_d           = idx_q + 1'b1;
          if (idx_q == IDX_W'(NBYTES - 1)) state_d = S_CHECK;
        end else if (timeout) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
        end
      end
      S_CHECK: begin
        if (rx_valid) begin
          state_d = S_IDLE;
          if (rx_data == xor_q) begin
            good       = 1'b1;
            frame_ok_d = 1'b1;
            pkt_d      = pkt_q + 4'd1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else if (timeout) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Boundary commit reads shadow_q, so a frame accepted in this same cycle
    // is not included; it re-arms pending for the next boundary below.
    if (cnt_q == '1 && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
      commit_d  = 1'b1;
    end

    if (good) begin
      pending_d = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        word        = {rx_buf_q[2*i], rx_buf_q[2*i+1]};
        shadow_d[i] = PWM_W'(word >> (16 - PWM_W));
      end
    end

    for (int i = 0; i < NUM_CH; i++) begin
      pwm_d[i] = (cnt_q < active_q[i]);
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      xor_q       <= '0;
      tmo_q       <= '0;
      rx_buf_q    <= '{default: '0};
      shadow_q    <= '{default: '0};
      active_q    <= '{default: '0};
      pending_q   <= 1'b0;
      cnt_q       <= '0;
      pwm_q       <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      commit_q    <= 1'b0;
      busy_q      <= 1'b0;
      pkt_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      xor_q       <= xor_d;
      tmo_q       <= tmo_d;
      rx_buf_q    <= rx_buf_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      cnt_q       <= cnt_d;
      pwm_q       <= pwm_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      commit_q    <= commit_d;
      busy_q      <= busy_d;
      pkt_q       <= pkt_d;
    end
  end

  assign pwm_out   = pwm_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign commit    = commit_q;
  assign busy      = busy_q;
  assign pkt_count = pkt_q;

endmodule

// File: tb/tb_uart_pwm_frame_ctrl.sv
// tb/tb_uart_pwm_frame_ctrl.sv - scoreboard bench for uart_pwm_frame_ctrl
module tb_uart_pwm_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [1:0] pwm_out;
  logic       frame_ok, frame_err, commit, busy;
  logic [3:0] pkt_count;

  uart_pwm_frame_ctrl #(
    .NUM_CH(2), .PWM_W(4), .SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .pwm_out(pwm_out), .frame_ok(frame_ok), .frame_err(frame_err),
    .commit(commit), .busy(busy), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // frame queue entry: {is_ok, expected pkt_count}; commit entry: {duty1, duty0}
  logic [4:0] exp_frame_q[$];
  logic [7:0] exp_commit_q[$];
  logic [3:0] exp_pkt = 4'd0;
  logic [3:0] m_cnt;
  int         meas_left = 0;
  int         hi0 = 0, hi1 = 0;
  logic [7:0] meas_exp = 8'h00;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference PWM phase: the count the DUT should hold in the current cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_cnt <= 4'd0;
    else        m_cnt <= m_cnt + 4'd1;
  end

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  initial begin
    logic [4:0] e;
    logic [7:0] c;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        meas_left = 0;
      end else begin
        if (meas_left > 0) begin
          hi0 += int'(pwm_out[0]);
          hi1 += int'(pwm_out[1]);
          meas_left--;
          if (meas_left == 0) begin
            check("pwm0_high_clocks", hi0, int'(meas_exp[3:0]));
            check("pwm1_high_clocks", hi1, int'(meas_exp[7:4]));
          end
        end
        if (commit) begin
          check("commit_at_wrap", int'(m_cnt), 0);
          checks++;
          if (exp_commit_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_commit: got commit expected none");
          end else begin
            c = exp_commit_q.pop_front();
            meas_exp  = c;
            hi0       = 0;
            hi1       = 0;
            meas_left = 16;
          end
        end
        if (frame_ok || frame_err) begin
          check("frame_ok_err_exclusive", int'(frame_ok & frame_err), 0);
          checks++;
          if (exp_frame_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame_event: got ok=%0d err=%0d expected none",
                     frame_ok, frame_err);
          end else begin
            e = exp_frame_q.pop_front();
            check("frame_kind_ok", int'(frame_ok), int'(e[4]));
            check("frame_pkt_count", int'(pkt_count), int'(e[3:0]));
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic push_good(input logic [3:0] e0, input logic [3:0] e1, input bit with_commit);
    exp_pkt = exp_pkt + 4'd1;
    exp_frame_q.push_back({1'b1, exp_pkt});
    if (with_commit) exp_commit_q.push_back({e1, e0});
  endtask

  task automatic send_frame(input logic [7:0] d0h, input logic [7:0] d0l,
                            input logic [7:0] d1h, input logic [7:0] d1l,
                            input bit good, input bit with_commit,
                            input logic [3:0] e0, input logic [3:0] e1);
    logic [7:0] cs;
    cs = d0h ^ d0l ^ d1h ^ d1l;
    if (!good) cs = cs ^ 8'h01;
    if (good) push_good(e0, e1, with_commit);
    else      exp_frame_q.push_back({1'b0, exp_pkt});
    send_byte(8'hA5);
    send_byte(d0h);
    send_byte(d0l);
    send_byte(d1h);
    send_byte(d1l);
    send_byte(cs);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_commit_q.size() != 0 || exp_frame_q.size() != 0 || meas_left != 0) && n < 120) begin
      tick();
      n++;
    end
    check(name, int'(n < 120), 1);
  endtask

  task automatic wait_phase(input logic [3:0] p);
    int n = 0;
    while (m_cnt != p && n < 20) begin
      tick();
      n++;
    end
    check("phase_align", int'(m_cnt), int'(p));
  endtask

  initial begin
    int hsum;
    repeat (2) tick();
    check("reset_pwm_out", int'(pwm_out), 0);
    check("reset_pkt_count", int'(pkt_count), 0);
    check("reset_pulses", int'({frame_ok, frame_err, commit}), 0);
    check("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Good frame: duties 8 and 4
    send_frame(8'h80, 8'h00, 8'h40, 8'h00, 1'b1, 1'b1, 4'h8, 4'h4);
    wait_drain("drain_good");
    check("pkt_after_good", int'(pkt_count), 1);

    // Bad checksum: error, no commit, count unchanged
    send_frame(8'h80, 8'h00, 8'h40, 8'h00, 1'b0, 1'b0, 4'h0, 4'h0);
    wait_drain("drain_bad");
    check("pkt_after_bad", int'(pkt_count), 1);

    // Timeout after 100 idle clocks
    exp_frame_q.push_back({1'b0, exp_pkt});
    send_byte(8'hA5);
    send_byte(8'h80);
    repeat (95) tick();
    check("busy_before_timeout", int'(busy), 1);
    repeat (10) tick();
    check("busy_after_timeout", int'(busy), 0);
    wait_drain("drain_timeout");
    send_frame(8'h80, 8'h00, 8'h40, 8'h00, 1'b1, 1'b1, 4'h8, 4'h4);
    wait_drain("drain_after_timeout");

    // Byte arriving on the exact expiry clock is accepted, no error
    push_good(4'h3, 4'h2, 1'b1);
    send_byte(8'hA5);
    repeat (99) tick();
    send_byte(8'h30);
    send_byte(8'h00);
    send_byte(8'h20);
    send_byte(8'h00);
    send_byte(8'h10);
    wait_drain("drain_expiry_edge");

    // Atomic boundary: duties 0x0000 / 0xFFFF landing mid-period
    wait_phase(4'd3);
    send_frame(8'h00, 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b1, 4'h0, 4'hF);
    wait_drain("drain_atomic");

    // Noise before sync, sync value inside payload
    push_good(4'hA, 4'h0, 1'b1);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'hA5);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'hA5);
    wait_drain("drain_noise");

    // Two good frames in one period: only the last is committed
    wait_phase(4'd1);
    send_frame(8'h20, 8'h00, 8'h30, 8'h00, 1'b1, 1'b0, 4'h2, 4'h3);
    send_frame(8'h50, 8'h00, 8'h60, 8'h00, 1'b1, 1'b1, 4'h5, 4'h6);
    wait_drain("drain_last_wins");

    // Second frame accepted on the boundary cycle: commits one period later
    wait_phase(4'd4);
    send_frame(8'h90, 8'h00, 8'h10, 8'h00, 1'b1, 1'b1, 4'h9, 4'h1);
    send_frame(8'h70, 8'h11, 8'hC0, 8'h22, 1'b1, 1'b1, 4'h7, 4'hC);
    wait_drain("drain_same_cycle");
    check("pkt_before_reset", int'(pkt_count), 9);

    // Reset mid-payload
    send_byte(8'hA5);
    send_byte(8'h80);
    send_byte(8'h00);
    rst_n = 1'b0;
    #1;
    check("midreset_pwm_out", int'(pwm_out), 0);
    check("midreset_pkt_count", int'(pkt_count), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_pulses", int'({frame_ok, frame_err, commit}), 0);
    exp_pkt = 4'd0;
    repeat (2) tick();
    rst_n = 1'b1;
    hsum = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      hsum += int'(pwm_out[0]) + int'(pwm_out[1]);
    end
    check("post_reset_pwm_low", hsum, 0);
    check("post_reset_busy", int'(busy), 0);

    // 16 good frames: count wraps to 0
    for (int i = 0; i < 16; i++) begin
      logic [3:0] d;
      d = 4'(i);
      send_frame({d, 4'h3}, 8'h5A, {~d, 4'h0}, 8'hC3, 1'b1, 1'b1, d, ~d);
      wait_drain("drain_wrap");
    end
    check("pkt_wrapped", int'(pkt_count), 0);

    check("frame_queue_empty", exp_frame_q.size(), 0);
    check("commit_queue_empty", exp_commit_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
